sim_end_monitor: RTL and testbench
==================================

Name: sim_end_monitor

Overview:
- Synthesisable, parametrised end-of-test monitor. It replaces the ad-hoc wait/timeout logic in the core testbench.
- Watches NUM_SRC end-condition sources, for example an ISA-test done flag (x26==1) and the CSR mends flag.
- Applies a settle window after reset and a programmable drain delay before sampling the verdict, then latches PASS/FAIL/SOFT_END/TIMEOUT plus a fail code and a cycle count.
- Instantiated beside sparrow_soc in the bench, and optionally on FPGA to drive a result LED/UART.

Parameters:
- NUM_SRC, 2, number of end-condition sources; index 0 is the highest priority.
- VERDICT_MASK, 2'b01, bit i=1: source i is a verdict source (pass_i decides PASS/FAIL); bit i=0: source i yields SOFT_END.
- CODE_W, 32, width of code_i / fail_code_o (test number register).
- CNT_W, 32, width of the cycle counter and timeout compare.
- SETTLE_CYC, 90, cycles after reset release during which done_i is ignored.
- DRAIN_CYC, 1, cycles between end detection and verdict sampling (must be >=1).
- TIMEOUT_CYC, 30000, cycles after reset release at which TIMEOUT fires; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  monitor enable; while 0 the counter and FSM hold.
- done_i  in  NUM_SRC  level end flags, one per source.
- pass_i  in  1  pass flag (e.g. x27==1), sampled at the end of drain.
- code_i  in  CODE_W  fail code (e.g. x3), sampled at the end of drain.
- sim_end_o  out  1  1 once a terminal state is reached; sticky until reset.
- status_o  out  3  0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 SOFT_END, 5 SETTLE.
- src_o  out  max(1,$clog2(NUM_SRC))  index of the terminating source; 0 on timeout.
- fail_code_o  out  CODE_W  code_i captured on FAIL, else 0.
- cycles_o  out  CNT_W  enabled cycles since reset release, frozen at termination.

Behaviour:
- Reset (async, rst_n=0) forces every output and register to 0, except status_o=5 (SETTLE) and state=SETTLE.
- The cycle counter increments on every clk with en_i=1 while the state is not terminal. It saturates at all-ones and never wraps.
- FSM states: SETTLE, ARMED, DRAIN, DONE.
- SETTLE → ARMED when cycles_o reaches SETTLE_CYC-1 with en_i=1. SETTLE_CYC=0 enters ARMED on the first enabled cycle.
  - done_i is ignored in SETTLE.
  - Timeout is still evaluated in SETTLE.
- ARMED: detect = |done_i. On detect, register the lowest set index as src, load the drain counter with DRAIN_CYC-1, and go to DRAIN.
  - status_o stays 0 throughout ARMED and DRAIN.
- DRAIN: decrement each enabled cycle. The drain counter reaching 0 means DONE on the next edge.
  - In that same cycle sample pass_i and code_i.
  - If VERDICT_MASK[src]=1: status=1 when pass_i=1, else status=2 with fail_code_o=code_i.
  - If VERDICT_MASK[src]=0: status=4.
- done_i deasserting during DRAIN does not abort. The source captured at detection is final.
- Timeout: when TIMEOUT_CYC!=0 and cycles_o==TIMEOUT_CYC-1 with en_i=1 in SETTLE or ARMED, go to DONE with status=3 and src_o=0.
  - If detect and timeout occur in the same ARMED cycle, detect wins.
  - Timeout is not checked in DRAIN; a drain always completes.
- DONE is terminal and absorbing. sim_end_o rises in the same edge that writes status, so there is one-cycle latency from the end of drain.
- With en_i=0 nothing changes, including the drain counter. done_i pulses during en_i=0 are missed by design.
- Reset mid-DRAIN or in DONE returns immediately to SETTLE with all outputs cleared.
- Inputs are synchronous to clk; no synchronisers. X on done_i is treated as 0 by the bench (compare with ===1 before driving).

Decomposition:
- Package sim_mon_pkg holds:
  - status_e enum (RUN=0, PASS=1, FAIL=2, TIMEOUT=3, SOFT_END=4, SETTLE=5);
  - state_e enum (SETTLE, ARMED, DRAIN, DONE);
  - a function that returns the lowest set bit index of a NUM_SRC vector.
- One natural sub-module, sim_mon_prio_enc: a parametrised priority encoder producing {valid, index} from done_i.
- The counter and FSM stay in the top.

Test Plan:
- rst_n low 10 cycles → status_o=5, sim_end_o=0, cycles_o=0. Release and hold done_i=0 → status_o=0 after 90 cycles, then timeout at cycle 29999 → status_o=3, sim_end_o=1, cycles_o=29999.
- done_i[0]=1 at cycle 200, pass_i=1 → with DRAIN_CYC=1, status_o=1 at cycle 202, src_o=0, fail_code_o=0.
- done_i[0]=1, pass_i=0, code_i=17 → status_o=2, fail_code_o=17, sim_end_o stays 1 for 1000 more cycles despite input changes.
- done_i=2'b11 in the same cycle → src_o=0. Alternatively done_i[1]=1 alone → status_o=4, pass_i ignored.
- done_i[0]=1 at cycle 50 (inside settle) then dropped → ignored, status_o remains 5→0. Also done_i[1] asserted on the exact timeout cycle → SOFT_END, not TIMEOUT.
- DRAIN_CYC=4, en_i toggled low 3 cycles during drain → verdict delayed exactly 3 cycles. rst_n pulse mid-drain → all outputs 0 and status_o=5.

Source files
------------

// File: rtl/sim_mon_pkg.sv
// Shared types and helpers for the end-of-test monitor: verdict encoding,
// FSM state encoding and a lowest-set-bit helper for the source encoder.
package sim_mon_pkg;

    localparam int MAX_SRC = 32;

    typedef enum logic [2:0] {
        STAT_RUN      = 3'd0,
        STAT_PASS     = 3'd1,
        STAT_FAIL     = 3'd2,
        STAT_TIMEOUT  = 3'd3,
        STAT_SOFT_END = 3'd4,
        STAT_SETTLE   = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        S_SETTLE,
        S_ARMED,
        S_DRAIN,
        S_DONE
    } state_e;

    // Index of the lowest set bit among the first n bits; 0 when none is set.
    function automatic int unsigned lowest_set(input logic [MAX_SRC-1:0] vec,
                                               input int unsigned n);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if ((i < int'(n)) && vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sim_mon_prio_enc.sv
// Priority encoder over the end-condition sources: index 0 wins.
module sim_mon_prio_enc
    import sim_mon_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_SRC-1:0] req_ext;

    for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_ext
        if (gi < N) begin : g_src
            assign req_ext[gi] = req[gi];
        end else begin : g_pad
            assign req_ext[gi] = 1'b0;
        end
    end

    assign valid = |req;
    assign idx   = IDX_W'(lowest_set(req_ext, N));

endmodule

// File: rtl/sim_end_monitor.sv
// End-of-test monitor: settle window, source detection, drain delay, then a
// sticky PASS/FAIL/SOFT_END/TIMEOUT verdict with fail code and cycle count.
module sim_end_monitor
    import sim_mon_pkg::*;
#(
    parameter int                 NUM_SRC      = 2,
    parameter logic [NUM_SRC-1:0] VERDICT_MASK = 2'b01,
    parameter int                 CODE_W       = 32,
    parameter int                 CNT_W        = 32,
    parameter int                 SETTLE_CYC   = 90,
    parameter int                 DRAIN_CYC    = 1,
    parameter int                 TIMEOUT_CYC  = 30000,
    localparam int                IDX_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [NUM_SRC-1:0] done_i,
    input  logic               pass_i,
    input  logic [CODE_W-1:0]  code_i,
    output logic               sim_end_o,
    output logic [2:0]         status_o,
    output logic [IDX_W-1:0]   src_o,
    output logic [CODE_W-1:0]  fail_code_o,
    output logic [CNT_W-1:0]   cycles_o
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    state_e             state_reg, state_next;
    status_e            status_reg, status_next;
    logic [IDX_W-1:0]   src_reg, src_next;
    logic [CODE_W-1:0]  fail_code_reg, fail_code_next;
    logic [CNT_W-1:0]   cycles_reg, cycles_next;
    logic [DRAIN_W-1:0] drain_reg, drain_next;
    logic               sim_end_reg, sim_end_next;

    logic               det_valid;
    logic [IDX_W-1:0]   det_idx;
    logic               settle_hit;
    logic               timeout_hit;

    sim_mon_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (done_i),
        .valid (det_valid),
        .idx   (det_idx)
    );

    assign settle_hit  = (SETTLE_CYC == 0) || (cycles_reg == SETTLE_LAST);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cycles_reg == TIMEOUT_LAST);

    always_comb begin
        state_next     = state_reg;
        status_next    = status_reg;
        src_next       = src_reg;
        fail_code_next = fail_code_reg;
        cycles_next    = cycles_reg;
        drain_next     = drain_reg;
        sim_end_next   = sim_end_reg;

        if (en_i) begin
            unique case (state_reg)
                S_SETTLE: begin
                    if (timeout_hit) begin
                        state_next   = S_DONE;
                        status_next  = STAT_TIMEOUT;
                        src_next     = '0;
                        sim_end_next = 1'b1;
                    end else if (settle_hit) begin
                        state_next  = S_ARMED;
                        status_next = STAT_RUN;
                    end
                end
                S_ARMED: begin
                    // A detection in the timeout cycle still wins.
                    if (det_valid) begin
                        state_next = S_DRAIN;
                        src_next   = det_idx;
                        drain_next = DRAIN_LOAD;
                    end else if (timeout_hit) begin
                        state_next   = S_DONE;
                        status_next  = STAT_TIMEOUT;
                        src_next     = '0;
                        sim_end_next = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_reg == '0) begin
                        state_next   = S_DONE;
                        sim_end_next = 1'b1;
                        if (VERDICT_MASK[src_reg]) begin
                            if (pass_i) begin
                                status_next = STAT_PASS;
                            end else begin
                                status_next    = STAT_FAIL;
                                fail_code_next = code_i;
                            end
                        end else begin
                            status_next = STAT_SOFT_END;
                        end
                    end else begin
                        drain_next = drain_reg - DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_next = S_SETTLE;
                end
            endcase

            // The count freezes on the terminating edge itself.
            if ((state_next != S_DONE) && (cycles_reg != '1)) begin
                cycles_next = cycles_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_SETTLE;
            status_reg    <= STAT_SETTLE;
            src_reg       <= '0;
            fail_code_reg <= '0;
            cycles_reg    <= '0;
            drain_reg     <= '0;
            sim_end_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            status_reg    <= status_next;
            src_reg       <= src_next;
            fail_code_reg <= fail_code_next;
            cycles_reg    <= cycles_next;
            drain_reg     <= drain_next;
            sim_end_reg   <= sim_end_next;
        end
    end

    assign sim_end_o   = sim_end_reg;
    assign status_o    = status_reg;
    assign src_o       = src_reg;
    assign fail_code_o = fail_code_reg;
    assign cycles_o    = cycles_reg;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Bench for sim_end_monitor: two instances (default and short-window parameters)
// driven with randomized scenarios and checked against arithmetic predictions.
module tb_sim_end_monitor;

    localparam int S_P[2] = '{90, 10};
    localparam int D_P[2] = '{1, 4};
    localparam int T_P[2] = '{30000, 200};

    logic        clk;
    logic        rst_n;
    logic        en_v[2];
    logic [1:0]  done_v[2];
    logic        pass_v[2];
    logic [31:0] code_v[2];
    logic        sim_end_v[2];
    logic [2:0]  status_v[2];
    logic        src_v[2];
    logic [31:0] fail_code_v[2];
    logic [31:0] cycles_v[2];

    int total;
    int bad;

    sim_end_monitor u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_v[0]),
        .done_i      (done_v[0]),
        .pass_i      (pass_v[0]),
        .code_i      (code_v[0]),
        .sim_end_o   (sim_end_v[0]),
        .status_o    (status_v[0]),
        .src_o       (src_v[0]),
        .fail_code_o (fail_code_v[0]),
        .cycles_o    (cycles_v[0])
    );

    sim_end_monitor #(
        .SETTLE_CYC  (10),
        .DRAIN_CYC   (4),
        .TIMEOUT_CYC (200)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_v[1]),
        .done_i      (done_v[1]),
        .pass_i      (pass_v[1]),
        .code_i      (code_v[1]),
        .sim_end_o   (sim_end_v[1]),
        .status_o    (status_v[1]),
        .src_o       (src_v[1]),
        .fail_code_o (fail_code_v[1]),
        .cycles_o    (cycles_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            en_v[k]   = 1'b0;
            done_v[k] = 2'b00;
            pass_v[k] = 1'b0;
            code_v[k] = 32'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (status_v[d] !== 3'd5) begin
                bad++;
                $display("FAIL reset_status dut=%0d got=%0d want=5", d, status_v[d]);
            end
            total++;
            if (sim_end_v[d] !== 1'b0 || cycles_v[d] !== 32'd0 || src_v[d] !== 1'b0
                || fail_code_v[d] !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs dut=%0d got end=%b cyc=%0d src=%b code=%0d want all 0",
                         d, sim_end_v[d], cycles_v[d], src_v[d], fail_code_v[d]);
            end
        end
        $display("reset: status_a=%0d status_b=%0d end_a=%b end_b=%b",
                 status_v[0], status_v[1], sim_end_v[0], sim_end_v[1]);
        rst_n = 1'b1;
    endtask

    // detect_at: enabled-cycle index from which done_i carries bits (-1: never).
    // pass_mode: 0 pass low, 1 pass high, 2 random. en_mode: 0 always on,
    // 1 random gaps, 2 three-cycle stall inside the drain.
    task automatic run_case(input int d, input int detect_at, input logic [1:0] bits,
                            input int pass_mode, input int en_mode, input int post,
                            input string name);
        int S, D, T, det_e, term_e, armed_exp, exp_src, exp_status;
        bit is_to, finished, stall_used, ed;
        int e, e_before, abs_edges, rise_e, rise_abs, armed_e, post_cnt, stall_left, limit;
        logic exp_pass;
        logic [31:0] exp_code, exp_fail;

        S = S_P[d]; D = D_P[d]; T = T_P[d];
        det_e = (detect_at < 0) ? -1 : ((detect_at > S) ? detect_at : S);
        is_to = (T != 0) && ((det_e < 0) || (det_e > T - 1));
        term_e = is_to ? (T - 1) : (det_e + D);
        armed_exp = (S == 0) ? 0 : S - 1;
        exp_src = is_to ? 0 : (bits[0] ? 0 : 1);
        exp_pass = 1'b0; exp_code = 32'd0;
        e = 0; e_before = 0; abs_edges = 0; rise_e = -1; rise_abs = -1; armed_e = -1;
        post_cnt = 0; stall_left = 0; finished = 0; stall_used = 0;
        limit = 2 * term_e + post + 200;

        do_reset();
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            if (finished || en_mode == 1) begin
                ed = ($urandom_range(3) != 0);
            end else if (en_mode == 2) begin
                if (!stall_used && e == det_e + 1) begin
                    stall_used = 1;
                    stall_left = 3;
                end
                if (stall_left > 0) begin
                    ed = 1'b0;
                    stall_left--;
                end else begin
                    ed = 1'b1;
                end
            end else begin
                ed = 1'b1;
            end
            en_v[d] = ed;

            if (finished || !ed) begin
                done_v[d] = 2'($urandom);
            end else if (detect_at >= 0 && e >= detect_at) begin
                done_v[d] = (e > det_e) ? 2'($urandom) : bits;
            end else if (e >= S / 2 && e <= S / 2 + 1 && e < S) begin
                done_v[d] = 2'b01;
            end else begin
                done_v[d] = 2'b00;
            end

            pass_v[d] = (pass_mode == 2) ? 1'($urandom) : (pass_mode == 1);
            code_v[d] = $urandom;
            if (ed && !finished && e == term_e) begin
                exp_pass = pass_v[d];
                exp_code = code_v[d];
            end

            @(posedge clk);
            #1;
            abs_edges++;
            if (ed && !finished) begin
                e_before = e;
                e++;
            end
            if (armed_e == -1 && status_v[d] !== 3'd5) armed_e = ed ? e_before : -2;
            if (!finished && sim_end_v[d] === 1'b1) begin
                rise_e = ed ? e_before : -2;
                rise_abs = abs_edges;
                finished = 1;
            end
            if (finished) begin
                post_cnt++;
                if (post_cnt > post) break;
            end
        end
        en_v[d] = 1'b0;

        if (is_to) exp_status = 3;
        else if (exp_src == 0) exp_status = exp_pass ? 1 : 2;
        else exp_status = 4;
        exp_fail = (exp_status == 2) ? exp_code : 32'd0;

        total++;
        if (rise_e !== term_e) begin
            bad++;
            $display("FAIL %s_end_cycle got=%0d want=%0d", name, rise_e, term_e);
        end
        if (!is_to || T - 1 >= S) begin
            total++;
            if (armed_e !== armed_exp) begin
                bad++;
                $display("FAIL %s_armed_cycle got=%0d want=%0d", name, armed_e, armed_exp);
            end
        end
        if (en_mode != 1) begin
            total++;
            if (rise_abs !== term_e + 1 + ((en_mode == 2) ? 3 : 0)) begin
                bad++;
                $display("FAIL %s_end_edge got=%0d want=%0d", name, rise_abs,
                         term_e + 1 + ((en_mode == 2) ? 3 : 0));
            end
        end
        total++;
        if (status_v[d] !== 3'(exp_status)) begin
            bad++;
            $display("FAIL %s_status got=%0d want=%0d", name, status_v[d], exp_status);
        end
        total++;
        if (src_v[d] !== 1'(exp_src)) begin
            bad++;
            $display("FAIL %s_src got=%0d want=%0d", name, src_v[d], exp_src);
        end
        total++;
        if (fail_code_v[d] !== exp_fail) begin
            bad++;
            $display("FAIL %s_fail_code got=%0d want=%0d", name, fail_code_v[d], exp_fail);
        end
        total++;
        if (cycles_v[d] !== 32'(term_e)) begin
            bad++;
            $display("FAIL %s_cycles got=%0d want=%0d", name, cycles_v[d], term_e);
        end
        total++;
        if (sim_end_v[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s_sim_end got=%b want=1", name, sim_end_v[d]);
        end
        $display("case %s: dut=%0d detect_at=%0d bits=%b status=%0d src=%0d code=%0d cycles=%0d end_at=%0d",
                 name, d, detect_at, bits, status_v[d], src_v[d], fail_code_v[d],
                 cycles_v[d], rise_e);
    endtask

    task automatic test_reset_mid_drain();
        int S;
        S = S_P[1];
        do_reset();
        for (int k = 0; k < S + 3; k++) begin
            @(negedge clk);
            en_v[1]   = 1'b1;
            done_v[1] = (k >= S) ? 2'b01 : 2'b00;
            pass_v[1] = 1'b1;
        end
        @(posedge clk);
        #1;
        total++;
        if (status_v[1] !== 3'd0 || sim_end_v[1] !== 1'b0 || cycles_v[1] !== 32'(S + 3)) begin
            bad++;
            $display("FAIL mid_drain_before got status=%0d end=%b cyc=%0d want 0/0/%0d",
                     status_v[1], sim_end_v[1], cycles_v[1], S + 3);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (status_v[1] !== 3'd5 || sim_end_v[1] !== 1'b0 || cycles_v[1] !== 32'd0
            || src_v[1] !== 1'b0 || fail_code_v[1] !== 32'd0) begin
            bad++;
            $display("FAIL mid_drain_reset got status=%0d end=%b cyc=%0d src=%b code=%0d want 5/0/0/0/0",
                     status_v[1], sim_end_v[1], cycles_v[1], src_v[1], fail_code_v[1]);
        end
        $display("case reset_mid_drain: status=%0d end=%b cycles=%0d",
                 status_v[1], sim_end_v[1], cycles_v[1]);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        idle_inputs();

        test_reset();
        run_case(0, -1, 2'b00, 2, 0, 5, "timeout_a");
        run_case(0, 200, 2'b01, 1, 0, 5, "pass_a");
        run_case(0, 150, 2'b01, 0, 1, 1000, "fail_sticky_a");
        run_case(0, 120, 2'b11, 2, 1, 10, "both_src_a");
        run_case(1, 40, 2'b10, 2, 1, 10, "soft_end_b");
        run_case(1, 3, 2'b01, 2, 0, 10, "early_done_b");
        run_case(1, 199, 2'b10, 2, 1, 10, "timeout_tie_b");
        run_case(1, -1, 2'b00, 2, 1, 10, "timeout_b");
        run_case(1, 30, 2'b01, 1, 2, 10, "drain_stall_b");
        test_reset_mid_drain();
        for (int r = 0; r < 8; r++) begin
            int d;
            d = r % 2;
            run_case(d, (d == 0) ? int'($urandom_range(400)) : int'($urandom_range(220)),
                     2'($urandom_range(3, 1)), 2, 1, 20, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
